// File: rtl/csr_unit_pkg.sv
// Shared ISA constants for the machine-mode CSR block: CSR addresses,
// csr_op encodings, interrupt cause codes and mstatus/mie/mip bit positions.
package isa_shared;

    // Machine information registers (read-only space, addr[11:10] == 2'b11)
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // Machine trap setup / handling
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;

    // Machine counters
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    typedef enum logic [1:0] {
        CSR_NONE  = 2'd0,
        CSR_WRITE = 2'd1,
        CSR_SET   = 2'd2,
        CSR_CLEAR = 2'd3
    } csr_op_e;

    // Interrupt cause codes; they double as the mie/mip bit positions
    localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
    localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
    localparam logic [3:0] IRQ_CODE_MEI = 4'd11;

    localparam int MIE_MSIE_BIT = 3;
    localparam int MIE_MTIE_BIT = 7;
    localparam int MIE_MEIE_BIT = 11;

    // mstatus field positions
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LO   = 11;
    localparam int MSTATUS_MPP_HI   = 12;

    // Legalise an mtvec mode field: only direct (0) and, when enabled, vectored (1)
    function automatic logic [1:0] mtvec_mode_legal(input logic [1:0] mode, input logic vec_en);
        logic [1:0] res;
        if ((mode == 2'b01) && vec_en) begin
            res = 2'b01;
        end else begin
            res = 2'b00;
        end
        return res;
    endfunction

endpackage

// File: rtl/csr_unit_counter64.sv
// 64-bit event counter with increment enable and independent half-word
// writes; a write to either half takes precedence over the increment.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_en,
    input  logic        wr_lo_en,
    input  logic        wr_hi_en,
    input  logic [63:0] wdata,
    output logic [63:0] count
);

    logic [63:0] count_r;

    // Counter state: reset, half-word write, or increment
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 64'd0;
        end else if (wr_lo_en || wr_hi_en) begin
            if (wr_lo_en) begin
                count_r[31:0] <= wdata[31:0];
            end
            if (wr_hi_en) begin
                count_r[63:32] <= wdata[63:32];
            end
        end else if (inc_en) begin
            count_r <= count_r + 64'd1;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: CSR read/modify/write, trap and interrupt entry,
// mret, redirect generation and the mcycle/minstret counters.
module csr_unit
    import isa_shared::*;
#(
    parameter int              XLEN        = 32,
    parameter int              HART_ID     = 0,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter int              VECTORED_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_addr,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap,
    input  logic [3:0]      trap_cause,
    input  logic [XLEN-1:0] trap_value,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret,
    input  logic            retire,
    input  logic            irq_mei,
    input  logic            irq_msi,
    input  logic            irq_mti,
    input  logic            irq_take,
    output logic            irq_pending,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam bit              HAS_HI     = (XLEN == 32);
    localparam logic            VEC_EN     = (VECTORED_EN != 0);
    localparam logic [1:0]      MXL        = (XLEN == 64) ? 2'd2 : 2'd1;
    localparam logic [XLEN-1:0] MISA_VAL   = {MXL, {(XLEN-2){1'b0}}} | XLEN'(32'h0000_1100);
    localparam logic [1:0]      MTVEC_RST_MODE = mtvec_mode_legal(MTVEC_RESET[1:0], VEC_EN);

    // Architectural state
    logic            mie_bit_r;
    logic            mpie_r;
    logic            meie_r;
    logic            msie_r;
    logic            mtie_r;
    logic [XLEN-1:2] mtvec_base_r;
    logic [1:0]      mtvec_mode_r;
    logic [XLEN-1:0] mscratch_r;
    logic [XLEN-1:0] mepc_r;
    logic [XLEN-1:0] mcause_r;
    logic [XLEN-1:0] mtval_r;
    logic            redirect_valid_r;
    logic [XLEN-1:0] redirect_pc_r;

    // Combinational views and control
    csr_op_e         op_s;
    logic [XLEN-1:0] mstatus_s;
    logic [XLEN-1:0] mie_s;
    logic [XLEN-1:0] mip_s;
    logic [XLEN-1:0] mtvec_s;
    logic [XLEN-1:0] rdata_s;
    logic            impl_s;
    logic            illegal_s;
    logic            pending_s;
    logic            irq_entry_s;
    logic            mret_s;
    logic            csr_wr_s;
    logic [XLEN-1:0] csr_result_s;
    logic [3:0]      irq_code_s;
    logic [XLEN-1:0] irq_target_s;
    logic [63:0]     mcycle_s;
    logic [63:0]     minstret_s;
    logic [63:0]     cnt_wdata_s;
    logic            cyc_wr_lo_s;
    logic            cyc_wr_hi_s;
    logic            ins_wr_lo_s;
    logic            ins_wr_hi_s;

    assign op_s = csr_op_e'(csr_op);

    // Assemble the composite register views from their stored fields
    always_comb begin
        mstatus_s = '0;
        mstatus_s[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mstatus_s[MSTATUS_MPIE_BIT]              = mpie_r;
        mstatus_s[MSTATUS_MIE_BIT]               = mie_bit_r;
        mie_s = '0;
        mie_s[MIE_MEIE_BIT] = meie_r;
        mie_s[MIE_MSIE_BIT] = msie_r;
        mie_s[MIE_MTIE_BIT] = mtie_r;
        mip_s = '0;
        mip_s[MIE_MEIE_BIT] = irq_mei;
        mip_s[MIE_MSIE_BIT] = irq_msi;
        mip_s[MIE_MTIE_BIT] = irq_mti;
        mtvec_s = {mtvec_base_r, mtvec_mode_r};
    end

    // CSR read mux; unknown addresses read zero and are flagged unimplemented
    always_comb begin
        rdata_s = '0;
        impl_s  = 1'b1;
        case (csr_addr)
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: rdata_s = '0;
            CSR_MHARTID:  rdata_s = XLEN'(HART_ID);
            CSR_MISA:     rdata_s = MISA_VAL;
            CSR_MSTATUS:  rdata_s = mstatus_s;
            CSR_MIE:      rdata_s = mie_s;
            CSR_MTVEC:    rdata_s = mtvec_s;
            CSR_MSCRATCH: rdata_s = mscratch_r;
            CSR_MEPC:     rdata_s = mepc_r;
            CSR_MCAUSE:   rdata_s = mcause_r;
            CSR_MTVAL:    rdata_s = mtval_r;
            CSR_MIP:      rdata_s = mip_s;
            CSR_MCYCLE:   rdata_s = mcycle_s[XLEN-1:0];
            CSR_MINSTRET: rdata_s = minstret_s[XLEN-1:0];
            CSR_MCYCLEH: begin
                if (HAS_HI) begin
                    rdata_s[31:0] = mcycle_s[63:32];
                end else begin
                    impl_s = 1'b0;
                end
            end
            CSR_MINSTRETH: begin
                if (HAS_HI) begin
                    rdata_s[31:0] = minstret_s[63:32];
                end else begin
                    impl_s = 1'b0;
                end
            end
            default: impl_s = 1'b0;
        endcase
    end

    assign illegal_s   = (op_s != CSR_NONE) && (!impl_s || (csr_addr[11:10] == 2'b11));
    assign pending_s   = mie_bit_r & (|(mie_s & mip_s));
    assign irq_entry_s = !trap && irq_take && pending_s;
    assign mret_s      = !trap && !irq_entry_s && mret;
    assign csr_wr_s    = !rst && !trap && !irq_entry_s && !mret_s
                         && (op_s != CSR_NONE) && !illegal_s;

    // Read-modify-write result for the addressed CSR
    always_comb begin
        case (op_s)
            CSR_WRITE: csr_result_s = csr_wdata;
            CSR_SET:   csr_result_s = rdata_s | csr_wdata;
            CSR_CLEAR: csr_result_s = rdata_s & ~csr_wdata;
            default:   csr_result_s = rdata_s;
        endcase
    end

    // Highest-priority enabled pending interrupt and its trap target
    always_comb begin
        if (irq_mei && meie_r) begin
            irq_code_s = IRQ_CODE_MEI;
        end else if (irq_msi && msie_r) begin
            irq_code_s = IRQ_CODE_MSI;
        end else begin
            irq_code_s = IRQ_CODE_MTI;
        end
        if (mtvec_mode_r == 2'b01) begin
            irq_target_s = {mtvec_base_r, 2'b00} + XLEN'({irq_code_s, 2'b00});
        end else begin
            irq_target_s = {mtvec_base_r, 2'b00};
        end
    end

    // Main CSR state: reset, trap entry, interrupt entry, mret, then CSR writes
    always_ff @(posedge clk) begin
        if (rst) begin
            mie_bit_r        <= 1'b0;
            mpie_r           <= 1'b0;
            meie_r           <= 1'b0;
            msie_r           <= 1'b0;
            mtie_r           <= 1'b0;
            mtvec_base_r     <= MTVEC_RESET[XLEN-1:2];
            mtvec_mode_r     <= MTVEC_RST_MODE;
            mscratch_r       <= '0;
            mepc_r           <= '0;
            mcause_r         <= '0;
            mtval_r          <= '0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= '0;
        end else if (trap) begin
            mepc_r           <= {trap_pc[XLEN-1:2], 2'b00};
            mcause_r         <= XLEN'(trap_cause);
            mtval_r          <= trap_value;
            mpie_r           <= mie_bit_r;
            mie_bit_r        <= 1'b0;
            redirect_valid_r <= 1'b1;
            redirect_pc_r    <= {mtvec_base_r, 2'b00};
        end else if (irq_entry_s) begin
            mepc_r           <= {trap_pc[XLEN-1:2], 2'b00};
            mcause_r         <= {1'b1, {(XLEN-5){1'b0}}, irq_code_s};
            mtval_r          <= '0;
            mpie_r           <= mie_bit_r;
            mie_bit_r        <= 1'b0;
            redirect_valid_r <= 1'b1;
            redirect_pc_r    <= irq_target_s;
        end else if (mret_s) begin
            mie_bit_r        <= mpie_r;
            mpie_r           <= 1'b1;
            redirect_valid_r <= 1'b1;
            redirect_pc_r    <= mepc_r;
        end else begin
            redirect_valid_r <= 1'b0;
            if (csr_wr_s) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        mie_bit_r <= csr_result_s[MSTATUS_MIE_BIT];
                        mpie_r    <= csr_result_s[MSTATUS_MPIE_BIT];
                    end
                    CSR_MIE: begin
                        meie_r <= csr_result_s[MIE_MEIE_BIT];
                        msie_r <= csr_result_s[MIE_MSIE_BIT];
                        mtie_r <= csr_result_s[MIE_MTIE_BIT];
                    end
                    CSR_MTVEC: begin
                        mtvec_base_r <= csr_result_s[XLEN-1:2];
                        mtvec_mode_r <= mtvec_mode_legal(csr_result_s[1:0], VEC_EN);
                    end
                    CSR_MSCRATCH: mscratch_r <= csr_result_s;
                    CSR_MEPC:     mepc_r     <= {csr_result_s[XLEN-1:2], 2'b00};
                    CSR_MCAUSE:   mcause_r   <= csr_result_s;
                    CSR_MTVAL:    mtval_r    <= csr_result_s;
                    default: begin
                    end
                endcase
            end
        end
    end

    // Counter write data: on RV32 the same word feeds whichever half is addressed
    if (XLEN == 32) begin : g_cnt32
        assign cnt_wdata_s = {csr_result_s, csr_result_s};
    end else begin : g_cnt64
        assign cnt_wdata_s = csr_result_s[63:0];
    end

    assign cyc_wr_lo_s = csr_wr_s && (csr_addr == CSR_MCYCLE);
    assign cyc_wr_hi_s = csr_wr_s && (HAS_HI ? (csr_addr == CSR_MCYCLEH) : (csr_addr == CSR_MCYCLE));
    assign ins_wr_lo_s = csr_wr_s && (csr_addr == CSR_MINSTRET);
    assign ins_wr_hi_s = csr_wr_s && (HAS_HI ? (csr_addr == CSR_MINSTRETH) : (csr_addr == CSR_MINSTRET));

    csr_counter64 u_mcycle (
        .clk      (clk),
        .rst      (rst),
        .inc_en   (1'b1),
        .wr_lo_en (cyc_wr_lo_s),
        .wr_hi_en (cyc_wr_hi_s),
        .wdata    (cnt_wdata_s),
        .count    (mcycle_s)
    );

    csr_counter64 u_minstret (
        .clk      (clk),
        .rst      (rst),
        .inc_en   (retire),
        .wr_lo_en (ins_wr_lo_s),
        .wr_hi_en (ins_wr_hi_s),
        .wdata    (cnt_wdata_s),
        .count    (minstret_s)
    );

    assign csr_rdata      = rdata_s;
    assign csr_illegal    = illegal_s;
    assign irq_pending    = pending_s;
    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit (RV32 configuration): a table of single-cycle
// CSR accesses, hand-written trap/interrupt/counter sequences, and randomized
// traffic checked every cycle against a behavioural model of the CSR file.
module tb_csr_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap;
    logic [3:0]  trap_cause;
    logic [31:0] trap_value;
    logic [31:0] trap_pc;
    logic        mret;
    logic        retire;
    logic        irq_mei, irq_msi, irq_mti, irq_take;
    logic        irq_pending;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    csr_unit #(
        .XLEN(32), .HART_ID(5), .MTVEC_RESET(32'h0000_0103), .VECTORED_EN(1)
    ) dut (
        .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .trap(trap), .trap_cause(trap_cause),
        .trap_value(trap_value), .trap_pc(trap_pc), .mret(mret), .retire(retire),
        .irq_mei(irq_mei), .irq_msi(irq_msi), .irq_mti(irq_mti), .irq_take(irq_take),
        .irq_pending(irq_pending), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    // ---------------- behavioural model ----------------
    logic        m_mie, m_mpie;
    logic [31:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_rpc;
    logic [63:0] m_cyc, m_ins;
    logic        m_rv;

    // Values captured from the DUT in the last cycle
    logic [31:0] got_rdata, got_rpc;
    logic        got_ill, got_pend, got_rv;

    function automatic logic [31:0] legal_mtvec(input logic [31:0] v);
        logic [31:0] r;
        r = v & ~32'd3;
        if ((v & 32'd3) == 32'd1) r = r + 32'd1;
        return r;
    endfunction

    function automatic logic [31:0] mip_now();
        return (irq_mei ? 32'h800 : 32'h0) + (irq_msi ? 32'h8 : 32'h0) + (irq_mti ? 32'h80 : 32'h0);
    endfunction

    task automatic model_reset();
        m_mie = 1'b0; m_mpie = 1'b0; m_mie_reg = 32'h0; m_mtvec = legal_mtvec(32'h103);
        m_mscratch = 32'h0; m_mepc = 32'h0; m_mcause = 32'h0; m_mtval = 32'h0;
        m_cyc = 64'h0; m_ins = 64'h0; m_rv = 1'b0; m_rpc = 32'h0;
    endtask

    task automatic model_read(input logic [11:0] a, output logic ok, output logic [31:0] v);
        ok = 1'b1;
        v  = 32'h0;
        case (a)
            12'hF11, 12'hF12, 12'hF13: v = 32'h0;
            12'hF14: v = 32'd5;
            12'h301: v = (32'd1 << 30) + (32'd1 << 12) + (32'd1 << 8);
            12'h300: v = 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0);
            12'h304: v = m_mie_reg;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'h344: v = mip_now();
            12'hB00: v = m_cyc[31:0];
            12'hB80: v = m_cyc[63:32];
            12'hB02: v = m_ins[31:0];
            12'hB82: v = m_ins[63:32];
            default: ok = 1'b0;
        endcase
    endtask

    task automatic model_edge(input logic ill, input logic pend);
        logic [31:0] old, nv, base;
        logic        ok;
        int          code;
        logic [63:0] nc, ni;
        if (rst) begin
            model_reset();
            return;
        end
        nc = m_cyc + 64'd1;
        ni = m_ins + (retire ? 64'd1 : 64'd0);
        base = m_mtvec & ~32'd3;
        m_rv = 1'b0;
        if (trap) begin
            m_mepc = trap_pc & ~32'd3; m_mcause = {28'd0, trap_cause}; m_mtval = trap_value;
            m_mpie = m_mie; m_mie = 1'b0; m_rv = 1'b1; m_rpc = base;
        end else if (irq_take && pend) begin
            if (irq_mei && m_mie_reg[11]) code = 11;
            else if (irq_msi && m_mie_reg[3]) code = 3;
            else code = 7;
            m_mepc = trap_pc & ~32'd3; m_mcause = 32'h8000_0000 + code; m_mtval = 32'h0;
            m_mpie = m_mie; m_mie = 1'b0; m_rv = 1'b1;
            m_rpc = ((m_mtvec & 32'd3) == 32'd1) ? base + 4 * code : base;
        end else if (mret) begin
            m_mie = m_mpie; m_mpie = 1'b1; m_rv = 1'b1; m_rpc = m_mepc;
        end else if (csr_op != 2'd0 && !ill) begin
            model_read(csr_addr, ok, old);
            nv = (csr_op == 2'd1) ? csr_wdata : (csr_op == 2'd2) ? (old | csr_wdata) : (old & ~csr_wdata);
            case (csr_addr)
                12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h304: m_mie_reg = nv & 32'h888;
                12'h305: m_mtvec = legal_mtvec(nv);
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv & ~32'd3;
                12'h342: m_mcause = nv;
                12'h343: m_mtval = nv;
                12'hB00: nc = {m_cyc[63:32], nv};
                12'hB80: nc = {nv, m_cyc[31:0]};
                12'hB02: ni = {m_ins[63:32], nv};
                12'hB82: ni = {nv, m_ins[31:0]};
                default: ;
            endcase
        end
        m_cyc = nc;
        m_ins = ni;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic set_idle();
        rst = 1'b0; csr_addr = 12'h0; csr_op = 2'd0; csr_wdata = 32'h0;
        trap = 1'b0; trap_cause = 4'd0; trap_value = 32'h0; trap_pc = 32'h0;
        mret = 1'b0; retire = 1'b0; irq_take = 1'b0;
    endtask

    // One clock: inputs are already set (clock low). Check combinational outputs
    // and, after the edge, the registered redirect against the model.
    task automatic cycle();
        logic        ok, exp_ill, exp_pend;
        logic [31:0] exp_rdata;
        model_read(csr_addr, ok, exp_rdata);
        exp_ill  = (csr_op != 2'd0) && (!ok || (csr_addr[11:10] == 2'b11));
        exp_pend = m_mie && ((m_mie_reg & mip_now()) != 32'h0);
        #1;
        got_rdata = csr_rdata; got_ill = csr_illegal; got_pend = irq_pending;
        if (!rst) begin
            chk("model_rdata", got_rdata, exp_rdata);
            chk("model_illegal", {31'd0, got_ill}, {31'd0, exp_ill});
            chk("model_pending", {31'd0, got_pend}, {31'd0, exp_pend});
        end
        @(posedge clk);
        model_edge(exp_ill, exp_pend);
        #1;
        got_rv = redirect_valid; got_rpc = redirect_pc;
        chk("model_redirect_valid", {31'd0, got_rv}, {31'd0, m_rv});
        if (m_rv) chk("model_redirect_pc", got_rpc, m_rpc);
        @(negedge clk);
    endtask

    task automatic csr_access(input logic [11:0] a, input logic [1:0] op, input logic [31:0] w);
        csr_addr = a; csr_op = op; csr_wdata = w;
        cycle();
        csr_op = 2'd0;
    endtask

    task automatic read_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_access(a, 2'd0, 32'h0);
        chk(name, got_rdata, exp);
    endtask

    typedef struct {
        logic [11:0] addr;
        logic [1:0]  op;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[$];
    logic [11:0] addr_pool[$];

    initial begin
        irq_mei = 1'b0; irq_msi = 1'b0; irq_mti = 1'b0;
        set_idle();
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        chk("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("reset_redirect_pc", redirect_pc, 32'h0);
        read_chk("reset_mstatus", 12'h300, 32'h1800);
        read_chk("reset_mtvec_legalised", 12'h305, 32'h100);

        // Table of single-cycle accesses: rdata is the value before this cycle's write
        vecs.push_back('{12'h340, 2'd1, 32'hDEADBEEF, 32'h0,        1'b0});
        vecs.push_back('{12'h340, 2'd2, 32'h10,       32'hDEADBEEF, 1'b0});
        vecs.push_back('{12'h340, 2'd3, 32'hF,        32'hDEADBEFF, 1'b0});
        vecs.push_back('{12'h340, 2'd0, 32'h0,        32'hDEADBEF0, 1'b0});
        vecs.push_back('{12'hF14, 2'd1, 32'h1,        32'd5,        1'b1});
        vecs.push_back('{12'hF14, 2'd0, 32'h0,        32'd5,        1'b0});
        vecs.push_back('{12'h7FF, 2'd2, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{12'h7FF, 2'd0, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{12'h301, 2'd1, 32'h0,        32'h40001100, 1'b0});
        vecs.push_back('{12'h301, 2'd0, 32'h0,        32'h40001100, 1'b0});
        vecs.push_back('{12'hF11, 2'd1, 32'h1,        32'h0,        1'b1});
        vecs.push_back('{12'h300, 2'd1, 32'hFFFFFFFF, 32'h1800,     1'b0});
        vecs.push_back('{12'h300, 2'd3, 32'h8,        32'h1888,     1'b0});
        vecs.push_back('{12'h300, 2'd1, 32'h0,        32'h1880,     1'b0});
        vecs.push_back('{12'h300, 2'd0, 32'h0,        32'h1800,     1'b0});
        vecs.push_back('{12'h305, 2'd1, 32'h203,      32'h100,      1'b0});
        vecs.push_back('{12'h305, 2'd1, 32'h201,      32'h200,      1'b0});
        vecs.push_back('{12'h305, 2'd0, 32'h0,        32'h201,      1'b0});
        vecs.push_back('{12'h304, 2'd1, 32'hFFFFFFFF, 32'h0,        1'b0});
        vecs.push_back('{12'h304, 2'd1, 32'h0,        32'h888,      1'b0});
        vecs.push_back('{12'h341, 2'd1, 32'h1237,     32'h0,        1'b0});
        vecs.push_back('{12'h341, 2'd0, 32'h0,        32'h1234,     1'b0});
        vecs.push_back('{12'h344, 2'd1, 32'hFFFFFFFF, 32'h0,        1'b0});
        vecs.push_back('{12'h342, 2'd1, 32'h8000000B, 32'h0,        1'b0});
        vecs.push_back('{12'h342, 2'd0, 32'h0,        32'h8000000B, 1'b0});
        vecs.push_back('{12'hC00, 2'd0, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{12'hC00, 2'd1, 32'h5,        32'h0,        1'b1});
        for (int i = 0; i < vecs.size(); i++) begin
            csr_access(vecs[i].addr, vecs[i].op, vecs[i].wdata);
            chk($sformatf("vec%0d_rdata", i), got_rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_illegal", i), {31'd0, got_ill}, {31'd0, vecs[i].exp_ill});
        end

        // Trap entry and mret
        csr_access(12'h305, 2'd1, 32'h100);
        csr_access(12'h300, 2'd1, 32'h8);
        trap = 1'b1; trap_cause = 4'd2; trap_pc = 32'h40; trap_value = 32'h55;
        cycle();
        trap = 1'b0;
        chk("trap_redirect_valid", {31'd0, got_rv}, 32'd1);
        chk("trap_redirect_pc", got_rpc, 32'h100);
        read_chk("trap_mcause", 12'h342, 32'h2);
        chk("trap_redirect_drops", {31'd0, got_rv}, 32'd0);
        read_chk("trap_mepc", 12'h341, 32'h40);
        read_chk("trap_mtval", 12'h343, 32'h55);
        read_chk("trap_mstatus", 12'h300, 32'h1880);
        mret = 1'b1;
        cycle();
        mret = 1'b0;
        chk("mret_redirect_valid", {31'd0, got_rv}, 32'd1);
        chk("mret_redirect_pc", got_rpc, 32'h40);
        read_chk("mret_mstatus", 12'h300, 32'h1888);

        // Vectored timer interrupt
        csr_access(12'h305, 2'd1, 32'h201);
        csr_access(12'h304, 2'd1, 32'h80);
        irq_mti = 1'b1; irq_take = 1'b1; trap_pc = 32'h60;
        cycle();
        irq_take = 1'b0;
        chk("irq_pending", {31'd0, got_pend}, 32'd1);
        chk("irq_redirect_pc", got_rpc, 32'h21C);
        read_chk("irq_mcause", 12'h342, 32'h80000007);
        read_chk("irq_mtval", 12'h343, 32'h0);
        read_chk("irq_mepc", 12'h341, 32'h60);
        read_chk("irq_mip", 12'h344, 32'h80);
        irq_mti = 1'b0;

        // Trap wins over a same-cycle CSR write
        trap = 1'b1; trap_pc = 32'h80; trap_cause = 4'd5;
        csr_access(12'h341, 2'd1, 32'h999);
        trap = 1'b0;
        read_chk("trap_vs_write_mepc", 12'h341, 32'h80);

        // mcycle low-half wrap carries into mcycleh
        csr_access(12'hB80, 2'd1, 32'h0);
        csr_access(12'hB00, 2'd1, 32'hFFFFFFFF);
        read_chk("mcycleh_before_wrap", 12'hB80, 32'h0);
        read_chk("mcycleh_after_wrap", 12'hB80, 32'h1);
        read_chk("mcycle_after_wrap", 12'hB00, 32'h1);

        // Reset during a trap sequence
        csr_access(12'h300, 2'd2, 32'h8);
        trap = 1'b1; trap_pc = 32'h44;
        cycle();
        chk("pre_reset_redirect", {31'd0, got_rv}, 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0; trap = 1'b0;
        chk("reset_mid_trap_valid", {31'd0, got_rv}, 32'd0);
        chk("reset_mid_trap_pc", got_rpc, 32'h0);
        read_chk("reset_mid_trap_mstatus", 12'h300, 32'h1800);

        // Randomized traffic against the model
        addr_pool = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                      12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF11, 12'hF14, 12'h7FF,
                      12'h123, 12'hC00};
        for (int n = 0; n < 800; n++) begin
            rst        = ($urandom_range(0, 99) < 2);
            csr_addr   = addr_pool[$urandom_range(0, addr_pool.size() - 1)];
            csr_op     = 2'($urandom_range(0, 3));
            csr_wdata  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            trap       = ($urandom_range(0, 99) < 5);
            trap_cause = 4'($urandom_range(0, 15));
            trap_value = $urandom;
            trap_pc    = $urandom & ~32'd3;
            mret       = ($urandom_range(0, 99) < 6);
            retire     = $urandom_range(0, 1) == 1;
            irq_mei    = ($urandom_range(0, 3) == 0);
            irq_msi    = ($urandom_range(0, 3) == 0);
            irq_mti    = ($urandom_range(0, 2) == 0);
            irq_take   = ($urandom_range(0, 99) < 20);
            cycle();
        end
        set_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
